// File: rtl/uart_echo_buffered.sv
// Buffered UART echo: RX bytes queue in a FIFO, are optionally case-converted and
// re-issued to the TX port with a start/busy handshake. Optional macro: UART_ECHO_STATS_EN.
module uart_echo_buffered #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int CASE_MODE    = 0,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_error,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
`ifdef UART_ECHO_STATS_EN
  output logic [15:0]                drop_count,
`endif
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] pop_data_p0;
  logic              push_req, push_ok, pop, drop;

  function automatic logic [DATA_W-1:0] case_conv(input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = b;
    if (CASE_MODE == 1 && b >= DATA_W'('h61) && b <= DATA_W'('h7A))
      r = b - DATA_W'('h20);
    else if (CASE_MODE == 2 && b >= DATA_W'('h41) && b <= DATA_W'('h5A))
      r = b + DATA_W'('h20);
    return r;
  endfunction

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push_req = rx_valid & ~rx_error;
  assign push_ok  = push_req & ((fifo_level != LVL_FULL) | pop);
  assign drop     = push_req & ~push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef UART_ECHO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

  // Stage p0: converted byte captured at pop, so a same-cycle push into the freed slot cannot corrupt it
  always_ff @(posedge clk) begin
    if (pop) pop_data_p0 <= case_conv(mem[rd_ptr]);
  end

  // Stage p1: byte presented to the core, held from LOAD until the next pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tx_data <= '0;
    else if (state == LOAD) tx_data <= pop_data_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state == WAIT_BUSY) ? timer + TMR_W'(1) : '0;
    end
  end

  // The busy timeout keeps a missed request from stalling the echo path forever.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:  state_nxt = START;
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)                state_nxt = WAIT_DONE;
        else if (timer == TMR_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Bench for uart_echo_buffered: three instances (CASE_MODE 0/1/2) share stimulus and a
// behavioural UART core; expected bytes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_echo_buffered;
  localparam int DEPTH = 16;
  localparam int BT    = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int RESP = 0, HOLD = 1, MANUAL = 2, IGNORE = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic rx_valid = 1'b0, rx_error = 1'b0, tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic ts0, ts1, ts2, ov0, ov1, ov2;
  logic [7:0] td0, td1, td2;
  logic [LW-1:0] lv0, lv1, lv2;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] dc0, dc1, dc2;
`endif

  always #5 clk = ~clk;

  uart_echo_buffered #(.DATA_W(8), .DEPTH(DEPTH), .CASE_MODE(0), .BUSY_TIMEOUT(BT)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_start(ts0), .tx_data(td0), .fifo_level(lv0),
`ifdef UART_ECHO_STATS_EN
    .drop_count(dc0),
`endif
    .overflow(ov0));
  uart_echo_buffered #(.DATA_W(8), .DEPTH(DEPTH), .CASE_MODE(1), .BUSY_TIMEOUT(BT)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_start(ts1), .tx_data(td1), .fifo_level(lv1),
`ifdef UART_ECHO_STATS_EN
    .drop_count(dc1),
`endif
    .overflow(ov1));
  uart_echo_buffered #(.DATA_W(8), .DEPTH(DEPTH), .CASE_MODE(2), .BUSY_TIMEOUT(BT)) dut2 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
    .tx_busy(tx_busy), .tx_start(ts2), .tx_data(td2), .fifo_level(lv2),
`ifdef UART_ECHO_STATS_EN
    .drop_count(dc2),
`endif
    .overflow(ov2));

  typedef struct { logic [7:0] din; logic [7:0] e0; logic [7:0] e1; logic [7:0] e2; } vec_t;
  typedef struct packed { logic [7:0] e0; logic [7:0] e1; logic [7:0] e2; } exp_t;

  vec_t tbl [12];
  exp_t sb [$];
  int   starts_q [$];
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  int   core_mode = RESP;
  int   cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic err);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_error = err;
    tick();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic wait_busy(input string name, input int budget);
    for (int i = 0; i < budget && tx_busy !== 1'b1; i++) tick();
    check(name, 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || lv0 != '0); i++) tick();
    check(name, 32'(sb.size()), 32'd0);
    for (int i = 0; i < 12; i++) tick();
  endtask

  // Behavioural UART core: busy rises the cycle after tx_start and lasts 5 cycles.
  initial begin
    logic s;
    forever begin
      @(negedge clk);
      s = ts0;
      @(posedge clk);
      #1;
      case (core_mode)
        RESP: begin
          if (s) cnt = 5;
          else if (cnt > 0) cnt--;
          tx_busy = (cnt != 0);
        end
        HOLD:    begin cnt = 0; tx_busy = 1'b1; end
        IGNORE:  begin cnt = 0; tx_busy = 1'b0; end
        default: cnt = 0;
      endcase
    end
  end

  // Scoreboard consumer: every tx_start must match the oldest expected byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ts0) begin
        starts_q.push_back(cyc);
        check("start_sync", 32'({ts1, ts2}), 32'd3);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_tx_start: actual tx_data %0h required no transmission", td0);
        end else begin
          e = sb.pop_front();
          check("tx_data_mode0", 32'(td0), 32'(e.e0));
          check("tx_data_mode1", 32'(td1), 32'(e.e1));
          check("tx_data_mode2", 32'(td2), 32'(e.e2));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual time limit reached required bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    tbl[0]  = '{8'h61, 8'h61, 8'h41, 8'h61};
    tbl[1]  = '{8'h7A, 8'h7A, 8'h5A, 8'h7A};
    tbl[2]  = '{8'h31, 8'h31, 8'h31, 8'h31};
    tbl[3]  = '{8'h5A, 8'h5A, 8'h5A, 8'h7A};
    tbl[4]  = '{8'h60, 8'h60, 8'h60, 8'h60};
    tbl[5]  = '{8'h7B, 8'h7B, 8'h7B, 8'h7B};
    tbl[6]  = '{8'h40, 8'h40, 8'h40, 8'h40};
    tbl[7]  = '{8'h5B, 8'h5B, 8'h5B, 8'h5B};
    tbl[8]  = '{8'h6D, 8'h6D, 8'h4D, 8'h6D};
    tbl[9]  = '{8'h4D, 8'h4D, 8'h4D, 8'h6D};
    tbl[10] = '{8'h41, 8'h41, 8'h41, 8'h61};
    tbl[11] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

    #1 rst = 1'b1;
    #2;
    check("reset_tx_start", 32'(ts0), 32'd0);
    check("reset_tx_data", 32'(td0), 32'd0);
    check("reset_level", 32'(lv0), 32'd0);
    check("reset_overflow", 32'(ov0), 32'd0);
`ifdef UART_ECHO_STATS_EN
    check("reset_drop_count", 32'(dc0), 32'd0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single byte: tx_start three cycles after rx_valid
    starts_q.delete();
    n = cyc;
    push_exp(8'h41, 8'h41, 8'h61);
    drive_rx(8'h41, 1'b0);
    check("t1_level_after_push", 32'(lv0), 32'd1);
    tick();
    check("t1_level_after_pop", 32'(lv0), 32'd0);
    wait_drain("t1_drain", 100);
    check("t1_start_count", 32'(starts_q.size()), 32'd1);
    if (starts_q.size() > 0) check("t1_latency", 32'(starts_q[0] - n), 32'd3);

    // Table burst, back-to-back pushes
    for (int i = 0; i < 12; i++) begin
      push_exp(tbl[i].e0, tbl[i].e1, tbl[i].e2);
      drive_rx(tbl[i].din, 1'b0);
    end
    wait_drain("table_drain", 400);

    // rx_error discards the byte
    starts_q.delete();
    drive_rx(8'h41, 1'b1);
    drive_rx(8'h61, 1'b1);
    check("err_level", 32'(lv0), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("err_no_start", 32'(starts_q.size()), 32'd0);

    // Overflow while the core is held busy
    push_exp(8'h2A, 8'h2A, 8'h2A);
    drive_rx(8'h2A, 1'b0);
    wait_busy("ovf_busy", 20);
    core_mode = HOLD;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) push_exp(8'(8'h30 + i), 8'(8'h30 + i), 8'(8'h30 + i));
      drive_rx(8'(8'h30 + i), 1'b0);
    end
    check("ovf_level", 32'(lv0), 32'(DEPTH));
    check("ovf_level_mode1", 32'(lv1), 32'(DEPTH));
    check("ovf_flag", 32'(ov0), 32'd1);
`ifdef UART_ECHO_STATS_EN
    check("ovf_drop_count", 32'(dc0), 32'd2);
`endif

    // Full FIFO: push lands on the same cycle as the pop
    core_mode = MANUAL;
    tx_busy = 1'b0;
    tick();
    push_exp(8'h5F, 8'h5F, 8'h5F);
    drive_rx(8'h5F, 1'b0);
    check("full_pushpop_level", 32'(lv0), 32'(DEPTH));
    check("full_pushpop_overflow", 32'(ov0), 32'd1);
`ifdef UART_ECHO_STATS_EN
    check("full_pushpop_drops", 32'(dc0), 32'd2);
`endif
    core_mode = RESP;
    wait_drain("full_drain", 600);

    // Core never raises busy: timeout then next byte
    core_mode = IGNORE;
    tick();
    starts_q.delete();
    push_exp(8'h61, 8'h41, 8'h61);
    drive_rx(8'h61, 1'b0);
    push_exp(8'h5A, 8'h5A, 8'h7A);
    drive_rx(8'h5A, 1'b0);
    for (int i = 0; i < 60 && starts_q.size() < 2; i++) tick();
    check("tmo_start_count", 32'(starts_q.size()), 32'd2);
    if (starts_q.size() >= 2) check("tmo_gap", 32'(starts_q[1] - starts_q[0]), 32'(BT + 3));
    wait_drain("tmo_drain", 100);

    // Async reset in WAIT_DONE abandons the byte and the queued one
    core_mode = RESP;
    tick();
    push_exp(8'h63, 8'h43, 8'h63);
    drive_rx(8'h63, 1'b0);
    wait_busy("rst_busy", 20);
    drive_rx(8'h64, 1'b0);
    check("rst_pre_level", 32'(lv0), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_tx_start", 32'(ts0), 32'd0);
    check("rst_tx_data_mode0", 32'(td0), 32'd0);
    check("rst_tx_data_mode1", 32'(td1), 32'd0);
    check("rst_level", 32'(lv0), 32'd0);
    check("rst_overflow", 32'(ov0), 32'd0);
    check("rst_overflow_mode2", 32'(ov2), 32'd0);
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    starts_q.delete();
    for (int i = 0; i < 15; i++) tick();
    check("rst_no_start", 32'(starts_q.size()), 32'd0);

    push_exp(8'h6D, 8'h4D, 8'h6D);
    drive_rx(8'h6D, 1'b0);
    wait_drain("post_rst_drain", 100);
    check("post_rst_level_mode2", 32'(lv2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
